barrier_scroll_checker: RTL and testbench
=========================================

// Module: barrier_scroll_checker
// PURPOSE
//  Consumer end of the barrier-row path. Drives the 8-bit row count into the barrier generator and samples
//  the 3-lane barrier row it returns on every scroll tick. Keeps a scrolling map of DEPTH rows and detects a
//  collision between the bottom row and the player lane. Sits between the barrier generator and the
//  display/game-control logic.
// PARAMETERS
//  DEPTH      8    rows held in the scrolling map; legal range 2..32
//  CNT_WRAP   8'd8 value cnt_out reloads with after 8'd255, which skips the blank start-up rows (cnt < 7)
// PORTS
//  clk          in   1        system clock
//  rst          in   1        synchronous, active-high reset
//  start        in   1        level/pulse; starts a game from IDLE or HIT
//  scroll_tick  in   1        1-cycle pulse; advances the map by one row
//  barrier_in   in   3        barrier row from generator (bit i = lane i blocked), valid combinationally vs cnt_out
//  player_lane  in   3        one-hot player lane position
//  cnt_out      out  8        row count presented to generator
//  map_rows     out  3*DEPTH  row r at [3r+2:3r]; row 0 = bottom (player row)
//  running      out  1        1 while in RUN
//  game_over    out  1        1 while in HIT
//  hit_lane     out  3        lanes of row 0 that overlapped player_lane at the collision
//  score        out  16       barrier rows passed (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, map_rows=0, cnt_out=0, running=0, game_over=0, hit_lane=0, score=0.
//  FSM IDLE -> RUN on start (map and cnt already 0). RUN -> HIT on collision. HIT -> RUN on start; that cycle
//    clears map_rows, cnt_out and score. start is ignored while in RUN.
//  Collision (RUN only): coll = |(map_rows[2:0] & player_lane), evaluated each cycle. When coll=1, next
//    cycle: state=HIT, hit_lane <= row0 & player_lane. If player_lane=0, no collision. If player_lane is
//    multi-hot, any overlap counts as a collision.
//  Scroll (RUN, scroll_tick=1, coll=0): row[i] <= row[i+1] for i<DEPTH-1; row[DEPTH-1] <= barrier_in
//    sampled that same cycle. cnt_out <= cnt_out+1, except 8'd255 -> CNT_WRAP. Row 0 is discarded.
//  Simultaneous scroll_tick and coll: the collision wins. No shift, cnt_out unchanged, score unchanged.
//  In IDLE/HIT: scroll_tick is ignored; map_rows, cnt_out and hit_lane hold (map frozen for display in HIT).
//  A new row becomes visible at the top one cycle after the tick. Collision against a newly shifted-in
//    row 0 is flagged one cycle after it lands; game_over rises two cycles after the shifting tick.
//  Reset mid-game overrides everything in the same edge and returns all outputs to reset values.
// CONFIGURATION
//  BARRIER_SCORE_EN defined: on each committed scroll, score increments if the discarded row 0 was
//    nonzero; it saturates at 16'hFFFF and clears on reset and on the restart from HIT.
//  BARRIER_SCORE_EN undefined: the score port is kept and tied to 16'h0000; no counter logic is built.
// STRUCTURE
//  Shared package barrier_pkg: LANES=3, typedef logic [2:0] lane_t, state enum {IDLE,RUN,HIT},
//    CNT_BLANK=8'd7, CNT_WRAP default.
//  Sub-module barrier_row_shifter (DEPTH, shift_en, clear, row_in -> rows flat). The top module holds
//    the FSM, cnt_out, collision and score logic.
// TESTING
//  1 rst, start, 10 ticks with barrier_in=3'b000, player=3'b001 -> running=1, cnt_out=10, no game_over.
//  2 One tick with barrier_in=3'b100, DEPTH-1 ticks with 0, player=3'b001 -> row0=3'b100, no hit,
//    next tick score=1 (EN).
//  3 Same row 3'b100 with player=3'b100 -> game_over=1 two cycles after landing tick, hit_lane=3'b100,
//    map frozen on later ticks.
//  4 coll and scroll_tick asserted together -> no shift, cnt_out unchanged; start in HIT -> map=0,
//    cnt_out=0, running=1.
//  5 Run cnt_out to 8'd255, then tick -> cnt_out=8'd8. rst asserted mid-RUN -> all outputs 0 next cycle.
//  6 Build without BARRIER_SCORE_EN, repeat scenario 2 -> score stays 16'h0000.

Source files
------------

// File: rtl/barrier_pkg.sv
// Shared types and constants for the barrier-row scroll/collision path.
package barrier_pkg;

  localparam int unsigned LANES            = 3;
  localparam int unsigned CNT_W            = 8;
  localparam int unsigned SCORE_W          = 16;
  localparam logic [7:0]  CNT_BLANK        = 8'd7;
  localparam logic [7:0]  CNT_WRAP_DEFAULT = 8'd8;

  typedef logic [LANES-1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2
  } state_t;

  // Row counter advance; 8'd255 reloads past the blank start-up rows.
  function automatic logic [CNT_W-1:0] cnt_advance(input logic [CNT_W-1:0] cnt,
                                                   input logic [CNT_W-1:0] wrap);
    if (cnt == 8'hFF) begin
      return wrap;
    end
    return CNT_W'(cnt + CNT_W'(1));
  endfunction

endpackage

// File: rtl/barrier_row_shifter.sv
// Scrolling map of DEPTH barrier rows; row 0 (bottom) in the low bits, new rows enter at the top.
module barrier_row_shifter
  import barrier_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_en,
  input  logic                     clear,
  input  lane_t                    row_in,
  output logic [LANES*DEPTH-1:0]   rows
);

  localparam int unsigned MAP_W = LANES * DEPTH;

  logic [MAP_W-1:0] r_rows;

  // Clear takes priority so a restart never merges with a stale shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rows <= '0;
    end else if (clear) begin
      r_rows <= '0;
    end else if (shift_en) begin
      r_rows <= {row_in, r_rows[MAP_W-1:LANES]};
    end
  end

  assign rows = r_rows;

endmodule

// File: rtl/barrier_scroll_checker.sv
// Barrier-row consumer: game FSM, generator row count, collision detect and score.
// Optional feature: define BARRIER_SCORE_EN to build the saturating score counter.
module barrier_scroll_checker
  import barrier_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter logic [7:0]  CNT_WRAP = CNT_WRAP_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     scroll_tick,
  input  logic [2:0]               barrier_in,
  input  logic [2:0]               player_lane,
  output logic [7:0]               cnt_out,
  output logic [3*DEPTH-1:0]       map_rows,
  output logic                     running,
  output logic                     game_over,
  output logic [2:0]               hit_lane,
  output logic [15:0]              score
);

  localparam int unsigned MAP_W = LANES * DEPTH;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_coll;
  logic               w_shift;
  logic               w_clear;
  lane_t              w_row0;
  lane_t              w_overlap;
  logic [MAP_W-1:0]   w_rows;
  logic [CNT_W-1:0]   r_cnt;
  lane_t              r_hit_lane;
  logic               r_running;
  logic               r_game_over;

  assign w_row0    = w_rows[LANES-1:0];
  assign w_overlap = w_row0 & player_lane;
  assign w_coll    = (r_state == RUN) && (|w_overlap);

  // Next state and the per-cycle map controls; a collision suppresses the scroll.
  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_coll) begin
          w_state_nxt = HIT;
        end else if (scroll_tick) begin
          w_shift = 1'b1;
        end
      end
      HIT: begin
        if (start) begin
          w_state_nxt = RUN;
          w_clear     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_running   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_running   <= (w_state_nxt == RUN);
      r_game_over <= (w_state_nxt == HIT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_clear) begin
      r_cnt <= '0;
    end else if (w_shift) begin
      r_cnt <= cnt_advance(r_cnt, CNT_WRAP);
    end
  end

  // Lanes captured at the collision stay frozen for display until the next hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_lane <= '0;
    end else if (w_coll) begin
      r_hit_lane <= w_overlap;
    end
  end

  barrier_row_shifter #(
    .DEPTH (DEPTH)
  ) u_row_shifter (
    .clk      (clk),
    .rst      (rst),
    .shift_en (w_shift),
    .clear    (w_clear),
    .row_in   (barrier_in),
    .rows     (w_rows)
  );

`ifdef BARRIER_SCORE_EN
  logic [SCORE_W-1:0] r_score;

  // Counts non-empty rows leaving the bottom of the map, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_score <= '0;
    end else if (w_clear) begin
      r_score <= '0;
    end else if (w_shift && (|w_row0) && (r_score != 16'hFFFF)) begin
      r_score <= SCORE_W'(r_score + SCORE_W'(1));
    end
  end

  assign score = r_score;
`else
  assign score = 16'h0000;
`endif

  assign cnt_out   = r_cnt;
  assign map_rows  = w_rows;
  assign running   = r_running;
  assign game_over = r_game_over;
  assign hit_lane  = r_hit_lane;

endmodule

// File: tb/tb_barrier_scroll_checker.sv
// Self-checking bench: directed table, hand-written corner sequences and random stimulus vs a reference model.
module tb_barrier_scroll_checker;

  localparam int unsigned DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              scroll_tick = 1'b0;
  logic [2:0]        barrier_in = 3'b000;
  logic [2:0]        player_lane = 3'b000;
  logic [7:0]        cnt_out;
  logic [3*DEPTH-1:0] map_rows;
  logic              running;
  logic              game_over;
  logic [2:0]        hit_lane;
  logic [15:0]       score;

  int n_checks = 0;
  int n_fail   = 0;

  barrier_scroll_checker #(
    .DEPTH    (DEPTH),
    .CNT_WRAP (8'd8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .scroll_tick (scroll_tick),
    .barrier_in  (barrier_in),
    .player_lane (player_lane),
    .cnt_out     (cnt_out),
    .map_rows    (map_rows),
    .running     (running),
    .game_over   (game_over),
    .hit_lane    (hit_lane),
    .score       (score)
  );

  always #5 clk = ~clk;

  // Reference model: game mode as a small integer, map as an array of rows.
  int         m_mode;    // 0 idle, 1 playing, 2 crashed
  logic [2:0] m_map [DEPTH];
  int         m_cnt;
  int         m_score;
  logic [2:0] m_hit;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_update();
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_score = 0; m_hit = 3'b000;
      for (int i = 0; i < DEPTH; i++) m_map[i] = 3'b000;
    end else if (m_mode == 0) begin
      if (start) m_mode = 1;
    end else if (m_mode == 1) begin
      if ((m_map[0] & player_lane) != 3'b000) begin
        m_mode = 2;
        m_hit  = m_map[0] & player_lane;
      end else if (scroll_tick) begin
`ifdef BARRIER_SCORE_EN
        if (m_map[0] != 3'b000 && m_score < 65535) m_score++;
`endif
        for (int i = 0; i < DEPTH - 1; i++) m_map[i] = m_map[i+1];
        m_map[DEPTH-1] = barrier_in;
        m_cnt = (m_cnt == 255) ? 8 : m_cnt + 1;
      end
    end else begin
      if (start) begin
        m_mode = 1; m_cnt = 0; m_score = 0;
        for (int i = 0; i < DEPTH; i++) m_map[i] = 3'b000;
      end
    end
  endfunction

  function automatic void compare_all();
    logic [3*DEPTH-1:0] exp_map;
    for (int r = 0; r < DEPTH; r++) exp_map[3*r +: 3] = m_map[r];
    check("cnt_out", 64'(cnt_out), 64'(m_cnt));
    check("map_rows", 64'(map_rows), 64'(exp_map));
    check("running", 64'(running), 64'(m_mode == 1));
    check("game_over", 64'(game_over), 64'(m_mode == 2));
    check("hit_lane", 64'(hit_lane), 64'(m_hit));
    check("score", 64'(score), 64'(m_score));
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic r, input logic s, input logic t,
                       input logic [2:0] b, input logic [2:0] p);
    rst = r; start = s; scroll_tick = t; barrier_in = b; player_lane = p;
    step();
  endtask

  typedef struct {
    logic       r;
    logic       s;
    logic       t;
    logic [2:0] b;
    logic [2:0] p;
    logic [7:0] e_cnt;
    logic       e_run;
    logic       e_go;
    logic [2:0] e_hit;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int exp_score;
    // Directed table: reset, start, one barrier row walked to the bottom, hit, freeze, restart, reset.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 3'b001, 8'd0, 1'b0, 1'b0, 3'b000};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 3'b000, 3'b001, 8'd0, 1'b1, 1'b0, 3'b000};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 3'b100, 3'b001, 8'd1, 1'b1, 1'b0, 3'b000};
    for (int i = 3; i <= 9; i++)
      vecs[i] = '{1'b0, 1'b0, 1'b1, 3'b000, 3'b001, 8'(i - 1), 1'b1, 1'b0, 3'b000};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 3'b000, 3'b100, 8'd8, 1'b0, 1'b1, 3'b100};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 3'b011, 3'b100, 8'd8, 1'b0, 1'b1, 3'b100};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 3'b000, 3'b100, 8'd0, 1'b1, 1'b0, 3'b100};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 8'd0, 1'b0, 1'b0, 3'b000};

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].r, vecs[i].s, vecs[i].t, vecs[i].b, vecs[i].p);
      check("tbl_cnt", 64'(cnt_out), 64'(vecs[i].e_cnt));
      check("tbl_running", 64'(running), 64'(vecs[i].e_run));
      check("tbl_game_over", 64'(game_over), 64'(vecs[i].e_go));
      check("tbl_hit_lane", 64'(hit_lane), 64'(vecs[i].e_hit));
    end

    // Ten empty ticks: still running at count 10.
    drive(1'b1, 1'b0, 1'b0, 3'b000, 3'b001);
    drive(1'b0, 1'b1, 1'b0, 3'b000, 3'b001);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b1, 3'b000, 3'b001);
    check("ten_ticks_cnt", 64'(cnt_out), 64'd10);
    check("ten_ticks_running", 64'(running), 64'd1);

    // Barrier reaches row 0 beside the player and is scored when it leaves.
    drive(1'b1, 1'b0, 1'b0, 3'b000, 3'b001);
    drive(1'b0, 1'b1, 1'b0, 3'b000, 3'b001);
    drive(1'b0, 1'b0, 1'b1, 3'b100, 3'b001);
    for (int i = 0; i < DEPTH - 1; i++) drive(1'b0, 1'b0, 1'b1, 3'b000, 3'b001);
    check("pass_row0", 64'(map_rows[2:0]), 64'd4);
    check("pass_no_hit", 64'(game_over), 64'd0);
    drive(1'b0, 1'b0, 1'b1, 3'b000, 3'b001);
`ifdef BARRIER_SCORE_EN
    exp_score = 1;
`else
    exp_score = 0;
`endif
    check("pass_score", 64'(score), 64'(exp_score));

    // Landing row collides: game_over two cycles after the landing tick; a tick in the collision cycle is dropped.
    drive(1'b1, 1'b0, 1'b0, 3'b000, 3'b100);
    drive(1'b0, 1'b1, 1'b0, 3'b000, 3'b100);
    drive(1'b0, 1'b0, 1'b1, 3'b100, 3'b100);
    for (int i = 0; i < DEPTH - 1; i++) drive(1'b0, 1'b0, 1'b1, 3'b000, 3'b100);
    check("land_go_early", 64'(game_over), 64'd0);
    check("land_cnt", 64'(cnt_out), 64'd8);
    drive(1'b0, 1'b0, 1'b1, 3'b010, 3'b100);
    check("coll_tick_go", 64'(game_over), 64'd1);
    check("coll_tick_cnt", 64'(cnt_out), 64'd8);
    check("coll_tick_row0", 64'(map_rows[2:0]), 64'd4);
    check("coll_tick_hit", 64'(hit_lane), 64'd4);
    drive(1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
    check("restart_map", 64'(map_rows), 64'd0);
    check("restart_running", 64'(running), 64'd1);

    // Counter wrap 255 -> 8 with no player, then reset mid-run.
    drive(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
    drive(1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
    for (int i = 0; i < 255; i++) drive(1'b0, 1'b0, 1'b1, 3'($urandom), 3'b000);
    check("wrap_pre", 64'(cnt_out), 64'd255);
    drive(1'b0, 1'b0, 1'b1, 3'b111, 3'b000);
    check("wrap_post", 64'(cnt_out), 64'd8);
    drive(1'b1, 1'b0, 1'b1, 3'b111, 3'b111);
    check("rst_mid_cnt", 64'(cnt_out), 64'd0);
    check("rst_mid_map", 64'(map_rows), 64'd0);
    check("rst_mid_running", 64'(running), 64'd0);

    // Random play including empty and multi-hot player lanes.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
            1'($urandom),
            ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000,
            3'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
